// File: rtl/alu_pipe_if.sv
// Handshake bundle between the register-read stage, the ALU and writeback.
// master = operand source / result consumer, slave = ALU.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow, err
  );

endinterface

// File: rtl/alu_pipe.sv
// WIDTH-bit registered ALU with valid/ready handshakes, status flags and an
// iterative shift-add multiplier that holds the unit busy for WIDTH cycles.
module alu_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpXor = 4'b0100;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpNor = 4'b1100;
  localparam logic [3:0] OpMul = 4'b1000;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_q;
  logic             overflow_q;
  logic             err_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CntW-1:0]  cnt_q;

  logic             in_ready;
  logic             accept;
  logic             drain;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_o;
  logic             alu_err;
  logic             alu_is_mul;
  logic             alu_z;
  logic [WIDTH-1:0] acc_nxt;

  // No in_valid term here, so the source may depend on in_ready without a loop.
  assign in_ready = rst_n && (state_q == StIdle) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign drain    = out_valid_q && bus.out_ready;

  // ADD, SUB and SLT share one adder; subtraction is a + ~b + 1.
  always_comb begin
    is_sub   = (bus.op == OpSub) || (bus.op == OpSlt);
    b_eff    = is_sub ? ~bus.b : bus.b;
    add_full = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    sum      = add_full[WIDTH-1:0];
    add_ovf  = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
  end

  always_comb begin
    alu_res    = '0;
    alu_c      = 1'b0;
    alu_o      = 1'b0;
    alu_err    = 1'b0;
    alu_is_mul = 1'b0;
    case (bus.op)
      OpAnd: alu_res = bus.a & bus.b;
      OpOr:  alu_res = bus.a | bus.b;
      OpXor: alu_res = bus.a ^ bus.b;
      OpNor: alu_res = ~(bus.a | bus.b);
      OpAdd, OpSub: begin
        alu_res = sum;
        alu_c   = add_full[WIDTH];
        alu_o   = add_ovf;
      end
      OpSlt: begin
        alu_res = {{(WIDTH - 1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
        alu_c   = add_full[WIDTH];
      end
      OpMul: begin
        if (MUL_EN) begin
          alu_is_mul = 1'b1;
        end else begin
          alu_err = 1'b1;
        end
      end
      default: alu_err = 1'b1;
    endcase
    alu_z = (alu_res == '0);
  end

  assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      if (drain) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (alu_is_mul) begin
              state_q  <= StMul;
              mcand_q  <= bus.a;
              mplier_q <= bus.b;
              acc_q    <= '0;
              cnt_q    <= '0;
            end else begin
              // Overrides a same-edge drain: back-to-back results at full rate.
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              zero_q      <= alu_z;
              carry_q     <= alu_c;
              overflow_q  <= alu_o;
              err_q       <= alu_err;
            end
          end
        end
        StMul: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            result_q    <= acc_nxt;
            zero_q      <= (acc_nxt == '0);
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.err       = err_q;

  StallHoldsResult: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(result_q)));

  MulBlocksInput: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StMul) |-> !in_ready);

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed bench for alu_pipe (WIDTH=8) against a cycle-level
// behavioural model; a second instance covers the MUL_EN=0 build.
module tb_alu_pipe;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) if0 ();
  alu_pipe_if #(.WIDTH(W)) if1 ();

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  alu_pipe #(.WIDTH(W), .MUL_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int checks = 0;
  int errors = 0;

  // Model state: pending output {err,ovf,carry,zero,result}, MUL cycles left.
  logic        m_ov;
  logic [11:0] m_out;
  logic [11:0] m_pend;
  int          m_busy;
  bit          m_acc;

  localparam logic [3:0] OPS [10] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h6, 4'h7, 4'hC, 4'h8,
                                      4'hF, 4'h3};
  localparam logic [7:0] CORNERS [5] = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h01};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_op(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input bit mul_en);
    logic [7:0]  r;
    logic [15:0] p;
    logic        c, o, e;
    int          sa, sb;
    r  = '0;
    c  = 1'b0;
    o  = 1'b0;
    e  = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h4: r = a ^ b;
      4'hC: r = ~(a | b);
      4'h2: begin
        {c, r} = {1'b0, a} + {1'b0, b};
        o = (sa + sb > 127) || (sa + sb < -128);
      end
      4'h6: begin
        r = a - b;
        c = (a >= b);
        o = (sa - sb > 127) || (sa - sb < -128);
      end
      4'h7: begin
        r = (sa < sb) ? 8'd1 : 8'd0;
        c = (a >= b);
      end
      4'h8: begin
        if (mul_en) begin
          p = a * b;
          r = p[7:0];
        end else begin
          e = 1'b1;
        end
      end
      default: e = 1'b1;
    endcase
    return {e, o, c, (r == 8'd0), r};
  endfunction

  function automatic bit m_ready();
    return rst_n && (m_busy == 0) && (!m_ov || if0.out_ready);
  endfunction

  task automatic m_reset();
    m_ov   = 1'b0;
    m_out  = '0;
    m_busy = 0;
    m_acc  = 1'b0;
  endtask

  // Called at the rising edge, before the bench changes any input.
  task automatic model_step();
    bit rdy;
    if (!rst_n) return;
    rdy   = m_ready();
    m_acc = 1'b0;
    if (m_ov && if0.out_ready) m_ov = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_ov  = 1'b1;
        m_out = m_pend;
      end
    end
    if (if0.in_valid && rdy) begin
      m_acc = 1'b1;
      if (if0.op == 4'h8) begin
        m_busy = W;
        m_pend = ref_op(if0.op, if0.a, if0.b, 1'b1);
      end else begin
        m_ov  = 1'b1;
        m_out = ref_op(if0.op, if0.a, if0.b, 1'b1);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", if0.in_ready, m_ready());
      check("out_valid", if0.out_valid, m_ov);
      if (m_ov) begin
        check("result_flags", {if0.err, if0.overflow, if0.carry, if0.zero, if0.result}, m_out);
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [11:0] got, output int lat);
    int n;
    if0.op = op;
    if0.a = a;
    if0.b = b;
    if0.in_valid = 1'b1;
    if0.out_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_acc && n < 50);
    if (!m_acc) check("accept_timeout", 32'd0, 32'd1);
    if0.in_valid = 1'b0;
    lat = 0;
    while (!if0.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    got = {if0.err, if0.overflow, if0.carry, if0.zero, if0.result};
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [11:0] got;
    int          lat;
    logic [7:0]  exp_b2b [4];
    logic [7:0]  held;
    bit          hold;

    if0.in_valid = 1'b0; if0.op = '0; if0.a = '0; if0.b = '0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.op = '0; if1.a = '0; if1.b = '0; if1.out_ready = 1'b1;
    m_pend = '0;
    m_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", if0.in_ready, 32'd0);
    check("rst_out_valid", if0.out_valid, 32'd0);
    check("rst_result_flags", {if0.err, if0.overflow, if0.carry, if0.zero, if0.result}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Pin the model to hand-computed values.
    check("model_add", ref_op(4'h2, 8'h7F, 8'h01, 1'b1), 12'h480);
    check("model_slt", ref_op(4'h7, 8'h80, 8'h7F, 1'b1), 12'h201);
    check("model_mul", ref_op(4'h8, 8'd13, 8'd11, 1'b1), 12'h08F);

    do_op(4'h2, 8'h7F, 8'h01, got, lat);
    check("add_ovf", got, 12'h480);
    check("add_lat", lat, 0);
    do_op(4'h6, 8'h05, 8'h05, got, lat);
    check("sub_zero", got, 12'h300);
    do_op(4'h7, 8'hFF, 8'h01, got, lat);
    check("slt_neg1", got, 12'h201);
    do_op(4'h7, 8'h80, 8'h7F, got, lat);
    check("slt_min", got, 12'h201);
    do_op(4'hC, 8'h0F, 8'hF0, got, lat);
    check("nor", got, 12'h100);
    do_op(4'h8, 8'd13, 8'd11, got, lat);
    check("mul_13x11", got, 12'h08F);
    check("mul_lat", lat, W);
    do_op(4'h8, 8'h10, 8'h10, got, lat);
    check("mul_trunc", got, 12'h100);
    do_op(4'hF, 8'h12, 8'h34, got, lat);
    check("illegal", got, 12'h900);
    check("illegal_lat", lat, 0);
    tick();

    // Four back-to-back ops with the consumer always ready.
    exp_b2b = '{8'h03, 8'hF0, 8'h11, 8'h0F};
    if0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin if0.op = 4'h2; if0.a = 8'h01; if0.b = 8'h02; end
        1: begin if0.op = 4'h4; if0.a = 8'h0F; if0.b = 8'hFF; end
        2: begin if0.op = 4'h1; if0.a = 8'h10; if0.b = 8'h01; end
        default: begin if0.op = 4'h6; if0.a = 8'h10; if0.b = 8'h01; end
      endcase
      if0.in_valid = 1'b1;
      check("b2b_in_ready", if0.in_ready, 32'd1);
      tick();
      check("b2b_valid", if0.out_valid, 32'd1);
      check("b2b_result", if0.result, exp_b2b[i]);
    end

    // Consumer stalls for three cycles with a new op waiting.
    if0.op = 4'h2; if0.a = 8'h20; if0.b = 8'h20;
    if0.out_ready = 1'b0;
    held = if0.result;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", if0.in_ready, 32'd0);
      tick();
      check("stall_valid", if0.out_valid, 32'd1);
      check("stall_result", if0.result, held);
    end
    if0.out_ready = 1'b1;
    tick();
    check("stall_release", {if0.out_valid, if0.result}, {1'b1, 8'h40});
    if0.in_valid = 1'b0;
    tick();

    // Reset in the third cycle of a multiply aborts it.
    if0.op = 4'h8; if0.a = 8'h03; if0.b = 8'h03; if0.in_valid = 1'b1;
    tick();
    if0.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    m_reset();
    #1;
    check("mid_mul_rst_valid", if0.out_valid, 32'd0);
    check("mid_mul_rst_ready", if0.in_ready, 32'd0);
    tick();
    tick();
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_ready", if0.in_ready, 32'd1);
    do_op(4'h2, 8'd2, 8'd3, got, lat);
    check("post_rst_add", got, 12'h005);
    repeat (12) tick();

    // Randomized traffic; the source holds an op until it is accepted.
    for (int n = 0; n < 1500; n++) begin
      hold = if0.in_valid && !m_acc;
      if (!hold) begin
        if0.in_valid = ($urandom_range(0, 3) != 0);
        if0.op = OPS[$urandom_range(0, 9)];
        if0.a = ($urandom_range(0, 3) == 0) ? CORNERS[$urandom_range(0, 4)] : 8'($urandom);
        if0.b = ($urandom_range(0, 3) == 0) ? CORNERS[$urandom_range(0, 4)] : 8'($urandom);
      end
      if0.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b1;
    repeat (12) tick();

    // MUL_EN=0 build: op 1000 is illegal with single-cycle latency.
    if1.op = 4'h8; if1.a = 8'd3; if1.b = 8'd4; if1.in_valid = 1'b1;
    check("nomul_in_ready", if1.in_ready, 32'd1);
    tick();
    check("nomul_err",
          {if1.out_valid, if1.err, if1.overflow, if1.carry, if1.zero, if1.result},
          {1'b1, 12'h900});
    check("nomul_not_busy", if1.in_ready, 32'd1);
    if1.op = 4'h2;
    tick();
    if1.in_valid = 1'b0;
    check("nomul_add",
          {if1.out_valid, if1.err, if1.overflow, if1.carry, if1.zero, if1.result},
          {1'b1, 12'h007});
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
